// File: rtl/wbu_commit.sv
// Writeback/commit stage: owns the GPR file, writes completed results, redirects
// fetch to the next PC and counts retired instructions.
module wbu_commit #(
    parameter int              XLEN     = 32,
    parameter int              NR_REGS  = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_pl_valid,
    input  logic            in_reg_wen,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_wb_data,
    input  logic [XLEN-1:0] in_pc_target,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic [XLEN-1:0] pc_next,
    output logic            commit_valid,
    output logic [63:0]     commit_count
);
    localparam int IDX_W = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;

    typedef enum logic [1:0] {S_BOOT, S_IDLE, S_WRITE, S_REDIRECT} state_t;

    typedef struct packed {
        logic            pl_valid;
        logic            reg_wen;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] wb_data;
        logic [XLEN-1:0] pc_target;
    } payload_t;

    state_t          state, state_nxt;
    payload_t        pl;
    logic [XLEN-1:0] gpr [NR_REGS];
    logic            in_fire, pc_fire, gpr_we;

    // Address 0 and out-of-range indices read as zero.
    function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
        if (a == 5'd0 || int'(a) >= NR_REGS) return '0;
        return gpr[a[IDX_W-1:0]];
    endfunction

    assign rs1_data = rd_port(rs1_addr);
    assign rs2_data = rd_port(rs2_addr);

    // Handshake outputs are masked during reset so an abandoned redirect never commits.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        pc_valid     = 1'b0;
        pc_next      = pl.pc_target;
        commit_valid = 1'b0;
        case (state)
            S_BOOT: begin
                pc_valid = !rst;
                pc_next  = RESET_PC;
                if (pc_ready) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid && in_pl_valid) state_nxt = S_WRITE;
            end
            S_WRITE: state_nxt = S_REDIRECT;
            S_REDIRECT: begin
                pc_valid     = !rst;
                commit_valid = !rst && pc_ready;
                if (pc_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    assign in_fire = in_valid && in_ready;
    assign pc_fire = pc_valid && pc_ready;
    assign gpr_we  = (state == S_WRITE) && pl.pl_valid && pl.reg_wen &&
                     (pl.rd_addr != 5'd0) && (int'(pl.rd_addr) < NR_REGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_BOOT;
            pl           <= '0;
            commit_count <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                pl.pl_valid  <= in_pl_valid;
                pl.reg_wen   <= in_reg_wen;
                pl.rd_addr   <= in_rd_addr;
                pl.wb_data   <= in_wb_data;
                pl.pc_target <= in_pc_target;
            end
            if (pc_fire && state == S_REDIRECT) commit_count <= commit_count + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) gpr[i] <= '0;
        end else if (gpr_we) begin
            gpr[pl.rd_addr[IDX_W-1:0]] <= pl.wb_data;
        end
    end
endmodule

// File: tb/tb_wbu_commit.sv
// Directed plus randomized bench for wbu_commit against a register-file/counter model.
module tb_wbu_commit;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_pl_valid, in_reg_wen;
    logic [4:0]  in_rd_addr, rs1_addr, rs2_addr;
    logic [31:0] in_wb_data, in_pc_target, rs1_data, rs2_data, pc_next;
    logic        pc_valid, pc_ready, commit_valid;
    logic [63:0] commit_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model_regs [32];
    longint      model_count;

    wbu_commit #(.XLEN(32), .NR_REGS(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pl_valid(in_pl_valid),
        .in_reg_wen(in_reg_wen), .in_rd_addr(in_rd_addr), .in_wb_data(in_wb_data),
        .in_pc_target(in_pc_target),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_next(pc_next),
        .commit_valid(commit_valid), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r);
            rs2_addr = 5'(31 - r);
            #1;
            chk({tag, " rs1"}, 64'(rs1_data), 64'(model_regs[r]));
            chk({tag, " rs2"}, 64'(rs2_data), 64'(model_regs[31 - r]));
        end
    endtask

    // One instruction from IDLE: fire, write cycle, redirect stalled 'stall' cycles, retire.
    task automatic txn(input bit pl, input bit wen, input logic [4:0] rd,
                       input logic [31:0] data, input logic [31:0] tgt, input int stall);
        in_valid = 1; in_pl_valid = pl; in_reg_wen = wen; in_rd_addr = rd;
        in_wb_data = data; in_pc_target = tgt; pc_ready = (stall == 0);
        #1;
        chk("idle in_ready", 64'(in_ready), 64'd1);
        chk("idle pc_valid", 64'(pc_valid), 64'd0);
        tick();
        in_valid = 0;
        in_pl_valid = $urandom; in_reg_wen = $urandom; in_wb_data = $urandom;
        #1;
        if (!pl) begin
            chk("bubble in_ready", 64'(in_ready), 64'd1);
            chk("bubble pc_valid", 64'(pc_valid), 64'd0);
            chk("bubble commit", 64'(commit_valid), 64'd0);
            chk("bubble count", commit_count, 64'(model_count));
            return;
        end
        chk("write in_ready", 64'(in_ready), 64'd0);
        chk("write pc_valid", 64'(pc_valid), 64'd0);
        if (wen && rd != 0) model_regs[rd] = data;
        tick();
        rs1_addr = rd;
        #1;
        chk("T+2 pc_valid", 64'(pc_valid), 64'd1);
        chk("T+2 pc_next", 64'(pc_next), 64'(tgt));
        chk("T+2 rd read", 64'(rs1_data), 64'(model_regs[rd]));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1;
            #1;
            chk("stall in_ready", 64'(in_ready), 64'd0);
            chk("stall pc_next", 64'(pc_next), 64'(tgt));
            chk("stall pc_valid", 64'(pc_valid), 64'd1);
            chk("stall commit", 64'(commit_valid), 64'd0);
            tick();
        end
        in_valid = 0;
        pc_ready = 1;
        #1;
        chk("fire commit", 64'(commit_valid), 64'd1);
        chk("fire pc_next", 64'(pc_next), 64'(tgt));
        tick();
        pc_ready = 0;
        model_count++;
        #1;
        chk("post commit pulse", 64'(commit_valid), 64'd0);
        chk("post count", commit_count, 64'(model_count));
        chk("post in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; pc_ready = 0;
        tick(); tick();
        rst = 0;
        for (int r = 0; r < 32; r++) model_regs[r] = '0;
        model_count = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_pl_valid = 0; in_reg_wen = 0; in_rd_addr = 0;
        in_wb_data = 0; in_pc_target = 0; rs1_addr = 0; rs2_addr = 0; pc_ready = 0;
        do_reset();
        #1;
        // Boot offer held while fetch stalls.
        for (int i = 0; i < 5; i++) begin
            chk("boot pc_valid", 64'(pc_valid), 64'd1);
            chk("boot pc_next", 64'(pc_next), 64'(RESET_PC));
            chk("boot in_ready", 64'(in_ready), 64'd0);
            chk("boot count", commit_count, 64'd0);
            tick(); #1;
        end
        check_regs("reset regs");
        pc_ready = 1;
        #1;
        chk("boot fire commit", 64'(commit_valid), 64'd0);
        tick();
        pc_ready = 0;
        #1;
        chk("after boot in_ready", 64'(in_ready), 64'd1);
        chk("after boot pc_valid", 64'(pc_valid), 64'd0);
        chk("after boot count", commit_count, 64'd0);

        txn(1, 1, 5'd5, 32'hDEAD_BEEF, 32'h8000_0004, 0);
        txn(1, 1, 5'd0, 32'h0000_1234, 32'h8000_0008, 0);
        txn(0, 1, 5'd6, 32'hFFFF_FFFF, 32'h1111_1111, 0);
        check_regs("after bubble");
        txn(1, 1, 5'd9, 32'h0BAD_F00D, 32'h8000_000C, 3);
        txn(1, 0, 5'd10, 32'hCAFE_0000, 32'h8000_0010, 1);
        check_regs("directed regs");

        for (int n = 0; n < 40; n++)
            txn(($urandom_range(0, 4) != 0), $urandom, 5'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)));
        check_regs("random regs");

        // Reset during redirect abandons the commit.
        txn(1, 1, 5'd7, 32'h0000_0055, 32'h8000_0100, 0);
        in_valid = 1; in_pl_valid = 1; in_reg_wen = 1; in_rd_addr = 5'd7;
        in_wb_data = 32'h0000_0055; in_pc_target = 32'h8000_0200; pc_ready = 0;
        tick();
        in_valid = 0;
        tick();
        rs1_addr = 5'd7;
        #1;
        chk("pre-rst x7", 64'(rs1_data), 64'h55);
        chk("pre-rst pc_valid", 64'(pc_valid), 64'd1);
        rst = 1; pc_ready = 1;
        #1;
        chk("rst commit", 64'(commit_valid), 64'd0);
        tick();
        rst = 0; pc_ready = 0;
        for (int r = 0; r < 32; r++) model_regs[r] = '0;
        model_count = 0;
        #1;
        chk("rst pc_valid", 64'(pc_valid), 64'd1);
        chk("rst pc_next", 64'(pc_next), 64'(RESET_PC));
        chk("rst x7", 64'(rs1_data), 64'd0);
        chk("rst count", commit_count, 64'd0);
        chk("rst commit after", 64'(commit_valid), 64'd0);
        check_regs("after reset regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
